// File: rtl/cga_line_doubler.sv
// CGA 15 kHz to 31 kHz scan doubler: ping-pong line buffer, each
// stored line is replayed twice at the full clock rate.
module cga_line_doubler #(
    parameter int LINE_LEN = 912,
    parameter int IN_DIV   = 2,
    parameter int HS_START = 800,
    parameter int HS_WIDTH = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] video,
    input  logic       line_reset,
    output logic [3:0] dbl_video,
    output logic       dbl_hsync,
    output logic       dbl_odd
);

    localparam int AW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int PW = (IN_DIV > 1) ? $clog2(IN_DIV) : 1;

    localparam logic [AW-1:0] LAST    = AW'(LINE_LEN - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(IN_DIV - 1);
    localparam logic [PW-1:0] PH_INIT = PW'(1 % IN_DIV);
    localparam logic [AW:0]   HS_LO   = (AW+1)'(HS_START);
    localparam logic [AW:0]   HS_HI   = (AW+1)'(HS_START + HS_WIDTH);

    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_phase;
    logic [AW-1:0] rd_addr;
    logic          rd_half;
    logic [1:0]    valid;

    logic          we;
    logic          wb;
    logic [AW-1:0] wa;
    logic          rd_bank;
    logic          rd_end;
    logic          hs_now;

    logic [3:0]    mem [2][LINE_LEN];
    logic [3:0]    rd_data;
    logic          vld_d1;
    logic          hs_d1;
    logic          odd_d1;

    always_comb begin
        we      = 1'b0;
        wb      = wr_bank;
        wa      = wr_addr;
        rd_bank = ~wr_bank;
        rd_end  = (rd_addr == LAST);
        hs_now  = ({1'b0, rd_addr} >= HS_LO) && ({1'b0, rd_addr} < HS_HI);
        if (!reset) begin
            we = line_reset || (wr_phase == '0);
        end
        // A line_reset sample is the first pixel of the next bank
        if (line_reset) begin
            wb = ~wr_bank;
            wa = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wb][wa] <= video;
        end
        rd_data <= mem[rd_bank][rd_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank  <= 1'b0;
            wr_addr  <= '0;
            wr_phase <= '0;
            valid    <= 2'b00;
        end else if (line_reset) begin
            wr_bank        <= ~wr_bank;
            valid[wr_bank] <= 1'b1;
            wr_addr        <= AW'(1);
            wr_phase       <= PH_INIT;
        end else begin
            // Saturate so overlong lines keep rewriting the last entry
            if (wr_phase == '0 && wr_addr != LAST) begin
                wr_addr <= wr_addr + 1'b1;
            end
            wr_phase <= (wr_phase == PH_LAST) ? '0 : wr_phase + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr <= '0;
            rd_half <= 1'b0;
        end else if (line_reset) begin
            rd_addr <= '0;
            rd_half <= 1'b0;
        end else begin
            rd_addr <= rd_end ? '0 : rd_addr + 1'b1;
            if (rd_end) begin
                rd_half <= ~rd_half;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_d1    <= 1'b0;
            hs_d1     <= 1'b0;
            odd_d1    <= 1'b0;
            dbl_video <= 4'h0;
            dbl_hsync <= 1'b0;
            dbl_odd   <= 1'b0;
        end else begin
            vld_d1    <= valid[rd_bank];
            hs_d1     <= hs_now;
            odd_d1    <= rd_half;
            dbl_video <= vld_d1 ? rd_data : 4'h0;
            dbl_hsync <= hs_d1;
            dbl_odd   <= odd_d1;
        end
    end

endmodule

// File: tb/tb_cga_line_doubler.sv
// Directed bench for the CGA line doubler: table of per-line output
// checkpoints plus hand-written reset and sync-pulse sequences.
module tb_cga_line_doubler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] video;
    logic       line_reset;
    logic [3:0] dbl_video;
    logic       dbl_hsync;
    logic       dbl_odd;

    always #5 clk = ~clk;

    cga_line_doubler dut (
        .clk        (clk),
        .reset      (reset),
        .video      (video),
        .line_reset (line_reset),
        .dbl_video  (dbl_video),
        .dbl_hsync  (dbl_hsync),
        .dbl_odd    (dbl_odd)
    );

    typedef struct {
        int         line;
        int         off;
        logic [3:0] v;
        logic       hs;
        logic       odd;
    } vec_t;

    vec_t       tbl[$];
    int         n_vec   = 0;
    int         n_bad   = 0;
    int         line_no = 0;
    int         off     = -1;
    logic [3:0] base    = 4'h0;
    int         hs_hi   = 0;
    int         hs_rise = 0;
    logic       hs_prev = 1'b0;

    task automatic add(input int l, input int o, input logic [3:0] v,
                       input logic hs, input logic odd);
        vec_t e;
        e.line = l;
        e.off  = o;
        e.v    = v;
        e.hs   = hs;
        e.odd  = odd;
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [5:0] act,
                       input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {video,hs,odd}=%h want %h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, clock, then compare any table entry due now
    task automatic step(input bit lr);
        line_reset = lr;
        if (lr) begin
            line_no++;
            off = 0;
        end else begin
            off++;
        end
        video = 4'(off / 2) + base;
        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            if (tbl[i].line == line_no && tbl[i].off == off) begin
                chk($sformatf("line%0d_off%0d", line_no, off),
                    {dbl_video, dbl_hsync, dbl_odd},
                    {tbl[i].v, tbl[i].hs, tbl[i].odd});
            end
        end
        if (line_no == 1) begin
            if (dbl_hsync) hs_hi++;
            if (dbl_hsync && !hs_prev) hs_rise++;
        end
        hs_prev = dbl_hsync;
    endtask

    task automatic run_line(input int len, input logic [3:0] b);
        base = b;
        step(1'b1);
        repeat (len - 1) step(1'b0);
    endtask

    initial begin
        // line 0: no bank valid yet, sync still runs
        add(0, 10,   4'h0, 1'b0, 1'b0);
        add(0, 850,  4'h0, 1'b1, 1'b0);
        add(0, 1000, 4'h0, 1'b0, 1'b1);
        // line 1 replays line 0 data ((j+9)&15)
        add(1, 2,    4'h9, 1'b0, 1'b0);
        add(1, 17,   4'h8, 1'b0, 1'b0);
        add(1, 802,  4'h9, 1'b1, 1'b0);
        add(1, 1714, 4'h9, 1'b1, 1'b1);
        add(1, 1778, 4'h9, 1'b0, 1'b1);
        // line 2 replays line A (j&15)
        add(2, 2,    4'h0, 1'b0, 1'b0);
        add(2, 3,    4'h1, 1'b0, 1'b0);
        add(2, 17,   4'hF, 1'b0, 1'b0);
        add(2, 18,   4'h0, 1'b0, 1'b0);
        add(2, 801,  4'hF, 1'b0, 1'b0);
        add(2, 802,  4'h0, 1'b1, 1'b0);
        add(2, 865,  4'hF, 1'b1, 1'b0);
        add(2, 866,  4'h0, 1'b0, 1'b0);
        add(2, 913,  4'hF, 1'b0, 1'b0);
        add(2, 914,  4'h0, 1'b0, 1'b1);
        add(2, 920,  4'h6, 1'b0, 1'b1);
        // line 3 replays short line B ((j+12)&15, 500 samples)
        add(3, 2,    4'hC, 1'b0, 1'b0);
        add(3, 3,    4'hD, 1'b0, 1'b0);
        add(3, 501,  4'hF, 1'b0, 1'b0);
        add(3, 914,  4'hC, 1'b0, 1'b1);
        add(3, 1826, 4'hC, 1'b0, 1'b0);
        // line 4 replays long line C, addr 911 holds the last sample
        add(4, 2,    4'h5, 1'b0, 1'b0);
        add(4, 912,  4'h3, 1'b0, 1'b0);
        add(4, 913,  4'h6, 1'b0, 1'b0);
        add(4, 914,  4'h5, 1'b0, 1'b1);
        add(4, 999,  4'hA, 1'b0, 1'b1);

        reset      = 1'b0;
        line_reset = 1'b0;
        video      = 4'h0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", {dbl_video, dbl_hsync, dbl_odd}, 6'h00);
        reset = 1'b0;

        base = 4'h9;
        repeat (1824) step(1'b0);
        run_line(1824, 4'h0);
        chk("hsync_pulses", 6'(hs_rise), 6'd2);
        n_vec++;
        if (hs_hi != 128) begin
            n_bad++;
            $display("FAIL hsync_width: got %0d high clk want 128", hs_hi);
        end
        run_line(1000, 4'hC);
        run_line(2404, 4'h5);
        run_line(1000, 4'h0);

        #2 reset = 1'b1;
        #1;
        chk("async_reset", {dbl_video, dbl_hsync, dbl_odd}, 6'h00);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        line_no = 5;
        off     = -1;
        base    = 4'h0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            chk($sformatf("post_reset_%0d", i),
                {dbl_video, dbl_hsync, dbl_odd}, 6'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
